// File: rtl/cordic_post.sv
// Post-processing for the CORDIC vectoring core: gain compensation, full-circle angle restore
// and optional direction quantisation (enabled by defining CORDIC_POST_DIR_QUANT_EN).
module cordic_post #(
    parameter int unsigned DW       = 16,
    parameter int unsigned DW_DOT   = 4,
    parameter int unsigned DW_NOR   = 20,
    parameter int unsigned CORE_LAT = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   oct_hsync_i,
    input  logic [2:0]             oct_code_i,
    input  logic                   din_vsync_i,
    input  logic                   din_hsync_i,
    input  logic [DW+DW_DOT-1:0]   din_x_i,
    input  logic [DW_NOR-1:0]      din_z_i,
    output logic                   dout_vsync_o,
    output logic                   dout_hsync_o,
    output logic [DW-1:0]          dout_mag_o,
    output logic [DW_NOR-1:0]      dout_angle_o,
    output logic [1:0]             dout_dir_o,
    output logic                   align_err_o
);

    localparam int unsigned XW    = DW + DW_DOT;
    localparam int unsigned PW    = XW + 16;
    localparam int unsigned KGain = 39797;

    localparam logic [PW-1:0]     RndAdd  = PW'(1) << (15 + DW_DOT);
    localparam logic [DW_NOR-1:0] Quarter = DW_NOR'(1) << (DW_NOR - 2);
    localparam logic [DW_NOR-1:0] Half    = DW_NOR'(1) << (DW_NOR - 1);

    // Octant delay line: {hsync, sx, sy, swap}, tap lines up with din_*.
    logic [3:0] oct_dl_q [CORE_LAT];
    logic [3:0] oct_tap;

    assign oct_tap = oct_dl_q[CORE_LAT-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(CORE_LAT); i++) begin
                oct_dl_q[i] <= '0;
            end
        end else begin
            oct_dl_q[0] <= {oct_hsync_i, oct_code_i};
            for (int i = 1; i < int'(CORE_LAT); i++) begin
                oct_dl_q[i] <= oct_dl_q[i-1];
            end
        end
    end

    // Stage 1: gain multiply and first-quadrant fold.
    logic              vs1_q, hs1_q;
    logic [PW-1:0]     p_d, p_q;
    logic [DW_NOR-1:0] t1_d, t1_q;
    logic              sx_d, sy_d, sx1_q, sy1_q;

    always_comb begin
        p_d  = '0;
        t1_d = '0;
        sx_d = 1'b0;
        sy_d = 1'b0;
        if (din_hsync_i) begin
            p_d  = PW'(din_x_i) * PW'(KGain);
            t1_d = oct_tap[0] ? (Quarter - din_z_i) : din_z_i;
            sx_d = oct_tap[2];
            sy_d = oct_tap[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vs1_q <= 1'b0;
            hs1_q <= 1'b0;
            p_q   <= '0;
            t1_q  <= '0;
            sx1_q <= 1'b0;
            sy1_q <= 1'b0;
        end else begin
            vs1_q <= din_vsync_i;
            hs1_q <= din_hsync_i;
            p_q   <= p_d;
            t1_q  <= t1_d;
            sx1_q <= sx_d;
            sy1_q <= sy_d;
        end
    end

    // Stage 2: round-half-up magnitude and full-circle angle.
    logic              vs2_q, hs2_q;
    logic [PW-1:0]     p_rnd;
    logic [DW-1:0]     mag_d, mag2_q;
    logic [DW_NOR-1:0] ang_d, ang2_q;

    assign p_rnd = p_q + RndAdd;

    always_comb begin
        mag_d = '0;
        ang_d = '0;
        if (hs1_q) begin
            mag_d = DW'(p_rnd >> (16 + DW_DOT));
            unique case ({sx1_q, sy1_q})
                2'b00: ang_d = t1_q;
                2'b10: ang_d = Half - t1_q;
                2'b11: ang_d = Half + t1_q;
                2'b01: ang_d = '0 - t1_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vs2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            mag2_q <= '0;
            ang2_q <= '0;
        end else begin
            vs2_q  <= vs1_q;
            hs2_q  <= hs1_q;
            mag2_q <= mag_d;
            ang2_q <= ang_d;
        end
    end

    // Stage 3: output registers.
    logic              vs3_q, hs3_q;
    logic [DW-1:0]     mag3_q;
    logic [DW_NOR-1:0] ang3_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vs3_q  <= 1'b0;
            hs3_q  <= 1'b0;
            mag3_q <= '0;
            ang3_q <= '0;
        end else begin
            vs3_q  <= vs2_q;
            hs3_q  <= hs2_q;
            mag3_q <= hs2_q ? mag2_q : '0;
            ang3_q <= hs2_q ? ang2_q : '0;
        end
    end

`ifdef CORDIC_POST_DIR_QUANT_EN
    // Bins of (angle mod 180 deg) in 22.5 deg steps; boundaries land in the higher bin.
    localparam logic [DW_NOR-2:0] E1 = (DW_NOR-1)'(1) << (DW_NOR - 4);
    localparam logic [DW_NOR-2:0] E3 = E1 * 3;
    localparam logic [DW_NOR-2:0] E5 = E1 * 5;
    localparam logic [DW_NOR-2:0] E7 = E1 * 7;

    logic [DW_NOR-2:0] ang_half;
    logic [1:0]        dir_d, dir_q;

    assign ang_half = ang2_q[DW_NOR-2:0];

    always_comb begin
        dir_d = 2'd0;
        if (hs2_q) begin
            if (ang_half < E1) begin
                dir_d = 2'd0;
            end else if (ang_half < E3) begin
                dir_d = 2'd1;
            end else if (ang_half < E5) begin
                dir_d = 2'd2;
            end else if (ang_half < E7) begin
                dir_d = 2'd3;
            end else begin
                dir_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dir_q <= 2'd0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign dout_dir_o = dir_q;
`else
    assign dout_dir_o = 2'd0;
`endif

    // Sticky misalignment flag; a new mismatch outranks the frame-start clear.
    logic din_vs_prev_q;
    logic align_err_d, align_err_q;

    always_comb begin
        align_err_d = align_err_q;
        if (din_vsync_i && !din_vs_prev_q) begin
            align_err_d = 1'b0;
        end
        if (oct_tap[3] != din_hsync_i) begin
            align_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            din_vs_prev_q <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            din_vs_prev_q <= din_vsync_i;
            align_err_q   <= align_err_d;
        end
    end

    assign dout_vsync_o = vs3_q;
    assign dout_hsync_o = hs3_q;
    assign dout_mag_o   = mag3_q;
    assign dout_angle_o = ang3_q;
    assign align_err_o  = align_err_q;

endmodule

// File: tb/tb_cordic_post.sv
// Scoreboard bench for cordic_post: directed pixels, expected results queued at issue time.
module tb_cordic_post;

    localparam int L = 15;
`ifdef CORDIC_POST_DIR_QUANT_EN
    localparam bit Quant = 1'b1;
`else
    localparam bit Quant = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        oct_hsync;
    logic [2:0]  oct_code;
    logic        din_vsync, din_hsync;
    logic [19:0] din_x;
    logic [19:0] din_z;
    logic        dout_vsync, dout_hsync;
    logic [15:0] dout_mag;
    logic [19:0] dout_angle;
    logic [1:0]  dout_dir;
    logic        align_err;

    cordic_post dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .oct_hsync_i  (oct_hsync),
        .oct_code_i   (oct_code),
        .din_vsync_i  (din_vsync),
        .din_hsync_i  (din_hsync),
        .din_x_i      (din_x),
        .din_z_i      (din_z),
        .dout_vsync_o (dout_vsync),
        .dout_hsync_o (dout_hsync),
        .dout_mag_o   (dout_mag),
        .dout_angle_o (dout_angle),
        .dout_dir_o   (dout_dir),
        .align_err_o  (align_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int x; int z; int oct; int mag; int angle; int dir;} vec_t;
    typedef struct {int mag; int angle; int dir; int at;} exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int mag, input int angle, input int dir);
        exp_t e;
        e.mag   = mag;
        e.angle = angle;
        e.dir   = Quant ? dir : 0;
        e.at    = cyc + 3;
        sb.push_back(e);
    endtask

    // Monitor: every valid output pixel must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dout_hsync) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mag", dout_mag, e.mag);
                chk("angle", dout_angle, e.angle);
                chk("dir", dout_dir, e.dir);
                chk("latency_cycle", cyc, e.at);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_vsync"}, dout_vsync, 0);
        chk({tag, "_hsync"}, dout_hsync, 0);
        chk({tag, "_mag"}, dout_mag, 0);
        chk({tag, "_angle"}, dout_angle, 0);
        chk({tag, "_dir"}, dout_dir, 0);
        chk({tag, "_align_err"}, align_err, 0);
    endtask

    task automatic idle(input int n);
        oct_hsync = 0; oct_code = 0; din_hsync = 0; din_x = 0; din_z = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Oct pixel k at cycle k, din pixel j at cycle j+oct_off; rst_at >= 0 aborts with a reset.
    task automatic run_line(input int first, input int n, input int oct_off, input int rst_at);
        for (int k = 0; k < n + oct_off + 2; k++) begin
            int j;
            if (k == rst_at) begin
                rst_n = 0;
                oct_hsync = 0; oct_code = 0; din_hsync = 0; din_x = 0; din_z = 0;
                @(posedge clk); #1;
                chk_zero("midline_reset");
                sb.delete();
                rst_n = 1;
                return;
            end
            oct_hsync = (k < n);
            oct_code  = (k < n) ? 3'(vecs[first+k].oct) : 3'b000;
            j = k - oct_off;
            if (j >= 0 && j < n) begin
                din_hsync = 1;
                din_x = 20'(vecs[first+j].x);
                din_z = 20'(vecs[first+j].z);
                push(vecs[first+j].mag, vecs[first+j].angle, vecs[first+j].dir);
            end else begin
                din_hsync = 0; din_x = 0; din_z = 0;
            end
            if (oct_off != L && j == 0) chk("align_err_before_mismatch", align_err, 0);
            @(posedge clk); #1;
            if (oct_off != L && j == 0) chk("align_err_after_mismatch", align_err, 1);
        end
        idle(1);
    endtask

    initial begin
        //            x        z       oct     mag    angle   dir
        vecs[0]  = '{2635,    0,      3'b000, 100,   0,      0};
        vecs[1]  = '{2635,    0,      3'b100, 100,   524288, 0};
        vecs[2]  = '{2635,    0,      3'b001, 100,   262144, 2};
        vecs[3]  = '{3726,    131072, 3'b000, 141,   131072, 1};
        vecs[4]  = '{3726,    131072, 3'b011, 141,   917504, 3};
        vecs[5]  = '{0,       0,      3'b010, 0,     0,      0};
        vecs[6]  = '{0,       1000,   3'b110, 0,     525288, 0};
        vecs[7]  = '{16,      65536,  3'b101, 1,     327680, 3};
        vecs[8]  = '{1048575, 131071, 3'b111, 39797, 655361, 1};
        vecs[9]  = '{2635,    0,      3'b011, 100,   786432, 2};
        vecs[10] = '{0,       65536,  3'b000, 0,     65536,  1};
        vecs[11] = '{0,       65536,  3'b100, 0,     458752, 0};

        rst_n = 0; din_vsync = 0;
        oct_hsync = 0; oct_code = 0; din_hsync = 0; din_x = 0; din_z = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;
        idle(2);

        run_line(0, 12, L, -1);
        idle(4);
        chk("align_err_aligned_line", align_err, 0);

        // oct path one cycle late relative to the core path
        run_line(0, 1, L - 1, -1);
        idle(4);
        chk("align_err_sticky", align_err, 1);

        din_vsync = 1;
        @(posedge clk); #1;
        chk("align_err_cleared_by_vsync", align_err, 0);
        din_vsync = 0;
        @(posedge clk); #1;
        chk("dout_vsync_before", dout_vsync, 0);
        @(posedge clk); #1;
        chk("dout_vsync_delayed", dout_vsync, 1);
        idle(2);

        // vsync rise coinciding with a mismatch: the set must win
        din_vsync = 1; din_hsync = 1; din_x = 0; din_z = 0;
        push(0, 0, 0);
        @(posedge clk); #1;
        chk("align_err_set_wins", align_err, 1);
        din_vsync = 0; din_hsync = 0;
        idle(4);
        din_vsync = 1;
        @(posedge clk); #1;
        din_vsync = 0;
        chk("align_err_reclear", align_err, 0);
        idle(3);

        run_line(0, 12, L, L + 5);
        run_line(0, 12, L, -1);
        idle(4);
        chk("align_err_after_restart", align_err, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
